instr_result_checker: RTL and testbench

Hardware read-back checker that sits directly downstream of the instruction register. On a start pulse it sweeps read_pointer over an address range and captures each returned instruction_word. It recomputes the expected result from opc/op_a/op_b and compares it against the stored result. It reports per-address mismatches and final error/checked counts, replacing the bench-side read loop with a pipelined, one-address-per-cycle engine.

---
 rtl/instr_result_checker.sv | 134 +++++++++++++
 tb/tb_instr_result_checker.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_result_checker.sv
// Read-back checker for the instruction register: sweeps an address range,
// recomputes each entry's expected result from opc/op_a/op_b and flags mismatches.
module instr_result_checker #(
    parameter int ADDR_W = 5,
    parameter int OP_W   = 32,
    parameter int RES_W  = 64,
    parameter int CNT_W  = 6
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         first_addr,
    input  logic [ADDR_W-1:0]         last_addr,
    output logic [ADDR_W-1:0]         read_pointer,
    input  logic [3+2*OP_W+RES_W-1:0] instruction_word,
    output logic                      busy,
    output logic                      done,
    output logic                      mismatch_valid,
    output logic [ADDR_W-1:0]         mismatch_addr,
    output logic [RES_W-1:0]          mismatch_expected,
    output logic [CNT_W-1:0]          err_count,
    output logic [CNT_W-1:0]          checked_count
);

    localparam int WORD_W = 3 + 2*OP_W + RES_W;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DRAIN
    } state_t;

    state_t state, next_state;

    logic [ADDR_W-1:0] last_q;
    logic              s1_valid;
    logic [WORD_W-1:0] s1_word;
    logic [ADDR_W-1:0] s1_addr;

    logic [2:0]              s1_opc;
    logic [OP_W-1:0]         s1_op_a;
    logic [OP_W-1:0]         s1_op_b;
    logic [RES_W-1:0]        s1_result;
    logic signed [RES_W-1:0] ext_a;
    logic signed [RES_W-1:0] ext_b;
    logic signed [RES_W-1:0] expected;
    logic                    compare_fail;

    assign s1_opc    = s1_word[WORD_W-1 -: 3];
    assign s1_op_a   = s1_word[2*OP_W+RES_W-1 -: OP_W];
    assign s1_op_b   = s1_word[OP_W+RES_W-1 -: OP_W];
    assign s1_result = s1_word[RES_W-1:0];

    assign ext_a = {{(RES_W-OP_W){s1_op_a[OP_W-1]}}, s1_op_a};
    assign ext_b = {{(RES_W-OP_W){s1_op_b[OP_W-1]}}, s1_op_b};

    // Signed divide/modulo truncate toward zero; a zero divisor yields 0.
    always_comb begin
        expected = '0;
        case (s1_opc)
            3'd0: expected = '0;
            3'd1: expected = ext_a;
            3'd2: expected = ext_b;
            3'd3: expected = ext_a + ext_b;
            3'd4: expected = ext_a - ext_b;
            3'd5: expected = ext_a * ext_b;
            3'd6: if (ext_b != '0) expected = ext_a / ext_b;
            3'd7: if (ext_b != '0) expected = ext_a % ext_b;
            default: expected = '0;
        endcase
    end

    assign compare_fail = s1_valid && (expected != $signed(s1_result));
    assign busy         = (state != IDLE);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SWEEP;
            SWEEP:   if (read_pointer == last_q) next_state = DRAIN;
            DRAIN:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Issue address, capture stage 1, compare at stage 2.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_pointer      <= '0;
            last_q            <= '0;
            s1_valid          <= 1'b0;
            s1_word           <= '0;
            s1_addr           <= '0;
            done              <= 1'b0;
            mismatch_valid    <= 1'b0;
            mismatch_addr     <= '0;
            mismatch_expected <= '0;
            err_count         <= '0;
            checked_count     <= '0;
        end else begin
            done           <= (state == DRAIN);
            mismatch_valid <= 1'b0;
            s1_valid       <= (state == SWEEP);
            if (state == SWEEP) begin
                s1_word <= instruction_word;
                s1_addr <= read_pointer;
            end

            if (state == IDLE && start) begin
                read_pointer  <= first_addr;
                last_q        <= last_addr;
                err_count     <= '0;
                checked_count <= '0;
            end else begin
                if (state == SWEEP && read_pointer != last_q)
                    read_pointer <= read_pointer + 1'b1;
                if (s1_valid)
                    checked_count <= checked_count + 1'b1;
                if (compare_fail) begin
                    err_count         <= err_count + 1'b1;
                    mismatch_valid    <= 1'b1;
                    mismatch_addr     <= s1_addr;
                    mismatch_expected <= expected;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_result_checker.sv
// Directed bench for instr_result_checker: a behavioural register array feeds
// instruction_word, and every observation is checked with an immediate assertion.
module tb_instr_result_checker;

    localparam int ADDR_W = 5;
    localparam int OP_W   = 32;
    localparam int RES_W  = 64;
    localparam int CNT_W  = 6;
    localparam int WORD_W = 3 + 2*OP_W + RES_W;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W-1:0] read_pointer;
    logic [WORD_W-1:0] instruction_word;
    logic              busy;
    logic              done;
    logic              mismatch_valid;
    logic [ADDR_W-1:0] mismatch_addr;
    logic [RES_W-1:0]  mismatch_expected;
    logic [CNT_W-1:0]  err_count;
    logic [CNT_W-1:0]  checked_count;

    logic [WORD_W-1:0] mem [32];

    int pass_count;
    int total_count;

    int                rp_trace [$];
    int                mm_edge  [$];
    logic [ADDR_W-1:0] mm_addr_q[$];
    logic [RES_W-1:0]  mm_exp_q [$];
    int                done_edge;

    instr_result_checker #(
        .ADDR_W(ADDR_W), .OP_W(OP_W), .RES_W(RES_W), .CNT_W(CNT_W)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .first_addr       (first_addr),
        .last_addr        (last_addr),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .busy             (busy),
        .done             (done),
        .mismatch_valid   (mismatch_valid),
        .mismatch_addr    (mismatch_addr),
        .mismatch_expected(mismatch_expected),
        .err_count        (err_count),
        .checked_count    (checked_count)
    );

    assign instruction_word = mem[read_pointer];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WORD_W-1:0] mk(input logic [2:0] opc,
                                             input logic signed [31:0] a,
                                             input logic signed [31:0] b,
                                             input logic signed [63:0] r);
        return {opc, a, b, r};
    endfunction

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected_val);
        total_count++;
        assert (observed === expected_val) pass_count++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected_val);
    endtask

    // Runs one sweep; optionally raises a second start during the edge busy_k.
    task automatic apply_stimulus(input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l,
                                  input int busy_k);
        int k;
        rp_trace.delete();
        mm_edge.delete();
        mm_addr_q.delete();
        mm_exp_q.delete();
        done_edge = -1;
        @(negedge clk);
        start = 1'b1;
        first_addr = f;
        last_addr = l;
        @(posedge clk);
        k = 0;
        while (k <= 45 && done_edge < 0) begin
            @(negedge clk);
            start = 1'b0;
            if (k == busy_k - 1) begin
                start = 1'b1;
                first_addr = 5'd9;
                last_addr = 5'd12;
            end
            rp_trace.push_back(int'(read_pointer));
            if (mismatch_valid) begin
                mm_edge.push_back(k);
                mm_addr_q.push_back(mismatch_addr);
                mm_exp_q.push_back(mismatch_expected);
            end
            if (done) done_edge = k;
            k++;
        end
        start = 1'b0;
    endtask

    initial begin
        pass_count  = 0;
        total_count = 0;
        reset_n     = 1'b0;
        start       = 1'b0;
        first_addr  = '0;
        last_addr   = '0;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        mem[0]  = mk(3'd3, 5, 3, 8);
        mem[1]  = mk(3'd4, -7, 2, -9);
        mem[2]  = mk(3'd5, -4, 6, -24);
        mem[3]  = mk(3'd7, -7, 3, -1);
        mem[7]  = mk(3'd6, 9, 0, 0);
        mem[8]  = mk(3'd7, -5, 0, 0);
        mem[30] = mk(3'd7, 7, -3, 1);
        mem[31] = mk(3'd6, -7, 2, -3);

        #12;
        check_output("rst_busy", 64'(busy), 64'd0);
        check_output("rst_rp", 64'(read_pointer), 64'd0);
        check_output("rst_done", 64'(done), 64'd0);
        check_output("rst_mmv", 64'(mismatch_valid), 64'd0);
        check_output("rst_err", 64'(err_count), 64'd0);
        check_output("rst_chk", 64'(checked_count), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] all-pass sweep 0..3");
        apply_stimulus(5'd0, 5'd3, -1);
        for (int i = 0; i < 4; i++) check_output("pass_rp", 64'(rp_trace[i]), 64'(i));
        check_output("pass_done_edge", 64'(done_edge), 64'd5);
        check_output("pass_err", 64'(err_count), 64'd0);
        check_output("pass_chk", 64'(checked_count), 64'd4);
        check_output("pass_mm_n", 64'(mm_edge.size()), 64'd0);
        check_output("pass_busy_after", 64'(busy), 64'd0);

        $display("[TB] single mismatch at addr 2");
        mem[2] = mk(3'd6, 15, 4, 4);
        apply_stimulus(5'd0, 5'd3, -1);
        check_output("mm_n", 64'(mm_edge.size()), 64'd1);
        if (mm_edge.size() > 0) begin
            check_output("mm_edge", 64'(mm_edge[0]), 64'd4);
            check_output("mm_addr", 64'(mm_addr_q[0]), 64'd2);
            check_output("mm_exp", mm_exp_q[0], 64'd3);
        end
        check_output("mm_err", 64'(err_count), 64'd1);
        check_output("mm_chk", 64'(checked_count), 64'd4);
        check_output("mm_exp_hold", mismatch_expected, 64'd3);

        $display("[TB] divide by zero 7..8");
        apply_stimulus(5'd7, 5'd8, -1);
        check_output("dz_rp0", 64'(rp_trace[0]), 64'd7);
        check_output("dz_rp1", 64'(rp_trace[1]), 64'd8);
        check_output("dz_mm_n", 64'(mm_edge.size()), 64'd0);
        check_output("dz_chk", 64'(checked_count), 64'd2);
        check_output("dz_err", 64'(err_count), 64'd0);
        check_output("dz_done_edge", 64'(done_edge), 64'd3);

        $display("[TB] wrap 30..1");
        mem[2] = mk(3'd6, 15, 4, 3);
        apply_stimulus(5'd30, 5'd1, -1);
        check_output("wrap_rp0", 64'(rp_trace[0]), 64'd30);
        check_output("wrap_rp1", 64'(rp_trace[1]), 64'd31);
        check_output("wrap_rp2", 64'(rp_trace[2]), 64'd0);
        check_output("wrap_rp3", 64'(rp_trace[3]), 64'd1);
        check_output("wrap_chk", 64'(checked_count), 64'd4);
        check_output("wrap_err", 64'(err_count), 64'd0);
        check_output("wrap_done_edge", 64'(done_edge), 64'd5);
        check_output("wrap_rp_hold", 64'(read_pointer), 64'd1);

        $display("[TB] start while busy");
        mem[2] = mk(3'd6, 15, 4, 4);
        apply_stimulus(5'd0, 5'd3, 2);
        check_output("bsy_done_edge", 64'(done_edge), 64'd5);
        check_output("bsy_chk", 64'(checked_count), 64'd4);
        check_output("bsy_err", 64'(err_count), 64'd1);
        check_output("bsy_rp_hold", 64'(read_pointer), 64'd3);
        check_output("bsy_rp3", 64'(rp_trace[3]), 64'd3);

        $display("[TB] full range 5..4");
        apply_stimulus(5'd5, 5'd4, -1);
        check_output("full_done_edge", 64'(done_edge), 64'd33);
        check_output("full_chk", 64'(checked_count), 64'd32);
        check_output("full_err", 64'(err_count), 64'd1);
        check_output("full_mm_n", 64'(mm_edge.size()), 64'd1);
        if (mm_edge.size() > 0) begin
            check_output("full_mm_edge", 64'(mm_edge[0]), 64'd31);
            check_output("full_mm_addr", 64'(mm_addr_q[0]), 64'd2);
        end
        check_output("full_rp_hold", 64'(read_pointer), 64'd4);

        $display("[TB] reset mid-sweep");
        mem[2] = mk(3'd6, 15, 4, 3);
        @(negedge clk);
        start = 1'b1;
        first_addr = 5'd0;
        last_addr = 5'd31;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_output("mid_busy", 64'(busy), 64'd0);
        check_output("mid_rp", 64'(read_pointer), 64'd0);
        check_output("mid_chk", 64'(checked_count), 64'd0);
        check_output("mid_err", 64'(err_count), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        apply_stimulus(5'd0, 5'd3, -1);
        check_output("post_chk", 64'(checked_count), 64'd4);
        check_output("post_err", 64'(err_count), 64'd0);
        check_output("post_done_edge", 64'(done_edge), 64'd5);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
